str_up_sample: RTL and testbench

STR_UP_SAMPLE -- requirements
Module: str_up_sample

---
 rtl/str_pkg.sv | 22 ++
 rtl/str_beat_counter.sv | 29 ++
 rtl/str_up_sample.sv | 116 +++++++++++
 tb/tb_str_up_sample.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/str_pkg.sv
// Shared stream definitions for the str_* blocks: FSM state encoding,
// beat flag bundle and a counter-width helper.
package str_pkg;

    // Up-sampler control state: IDLE holds no sample, EMIT repeats one.
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } str_state_t;

    // Side-band flags carried with every stream beat.
    typedef struct packed {
        logic valid;
        logic last;
    } str_beat_flags_t;

    // Counter width for a 0..max_count-1 counter; never narrower than 1 bit.
    function automatic int str_cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/str_beat_counter.sv
// Wrapping beat counter 0..MAX-1. 'wrap' flags the terminal count so the
// owner can see that the next enabled step returns to zero.
module str_beat_counter
    import str_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    output logic [str_cnt_width(MAX)-1:0]   cnt,
    output logic                            wrap
);

    localparam int            W   = str_cnt_width(MAX);
    localparam logic [W-1:0]  TOP = W'(MAX - 1);

    assign wrap = (cnt == TOP);

    // Advance one step per enabled cycle, folding back to zero after MAX-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/str_up_sample.sv
// Stream up-sampler: each accepted input sample is emitted as FACTOR output
// beats (held or zero-stuffed), with out_last marking every LAST-th beat.
// Output ports are registered; only in_ready is combinational.
module str_up_sample
    import str_pkg::*;
#(
    parameter int DW         = 24,
    parameter int FACTOR     = 10,
    parameter int LAST       = 10,
    parameter int ZERO_STUFF = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic signed [DW-1:0] out_data,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int            PW        = str_cnt_width(FACTOR);
    localparam int            FW        = str_cnt_width(LAST);
    localparam logic [FW-1:0] FRAME_TOP = FW'(LAST - 1);

    str_state_t          state;
    str_state_t          state_next;
    logic signed [DW-1:0] sample_q;
    logic signed [DW-1:0] sample_next;
    logic signed [DW-1:0] data_next;
    logic [PW-1:0]       phase_cnt;
    logic [PW-1:0]       phase_next;
    logic                phase_wrap;
    logic [FW-1:0]       frame_cnt;
    logic [FW-1:0]       frame_next;
    logic                frame_wrap;
    logic                transfer;
    logic                accept;

    // Phase within the current sample: advances once per delivered beat.
    str_beat_counter #(.MAX(FACTOR)) u_phase (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (transfer),
        .cnt   (phase_cnt),
        .wrap  (phase_wrap)
    );

    // Frame position: free-running across samples and idle gaps.
    str_beat_counter #(.MAX(LAST)) u_frame (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (transfer),
        .cnt   (frame_cnt),
        .wrap  (frame_wrap)
    );

    // Handshakes, next state, and the values the output registers load next.
    always_comb begin
        transfer    = out_valid && out_ready;
        in_ready    = (state == IDLE) || ((state == EMIT) && phase_wrap && out_ready);
        accept      = in_valid && in_ready;
        state_next  = state;
        sample_next = accept ? in_data : sample_q;
        phase_next  = transfer ? (phase_wrap ? '0 : phase_cnt + PW'(1)) : phase_cnt;
        frame_next  = transfer ? (frame_wrap ? '0 : frame_cnt + FW'(1)) : frame_cnt;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (transfer && phase_wrap) begin
                    state_next = accept ? EMIT : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if ((ZERO_STUFF != 0) && (phase_next != '0)) begin
            data_next = '0;
        end else begin
            data_next = sample_next;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Held sample and registered output beat for the coming cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_q  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            sample_q  <= sample_next;
            out_valid <= (state_next == EMIT);
            out_data  <= (state_next == EMIT) ? data_next : '0;
            out_last  <= (state_next == EMIT) && (frame_next == FRAME_TOP);
        end
    end

endmodule

// File: tb/tb_str_up_sample.sv
// Self-checking bench for str_up_sample. Two instances (hold and zero-stuff)
// share one stimulus stream; a beat-queue model predicts every output.
module tb_str_up_sample;

    localparam int DW_T     = 24;
    localparam int FACTOR_T = 4;
    localparam int LAST_T   = 6;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic signed [DW_T-1:0] in_data;
    logic                   in_valid;
    logic                   out_ready;

    logic                   in_ready0, in_ready1;
    logic signed [DW_T-1:0] out_data0, out_data1;
    logic                   out_last0, out_last1;
    logic                   out_valid0, out_valid1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        longint d0;
        longint d1;
        logic   last;
    } beat_t;

    typedef struct {
        int     cyc;
        longint d0;
        longint d1;
        logic   l0;
        logic   l1;
    } log_t;

    beat_t exp_q[$];
    log_t  log_q[$];
    int    beat_idx = 0;
    int    acc_cyc  = 0;

    str_up_sample #(.DW(DW_T), .FACTOR(FACTOR_T), .LAST(LAST_T), .ZERO_STUFF(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready0), .out_data(out_data0), .out_last(out_last0),
        .out_valid(out_valid0), .out_ready(out_ready)
    );

    str_up_sample #(.DW(DW_T), .FACTOR(FACTOR_T), .LAST(LAST_T), .ZERO_STUFF(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready1), .out_data(out_data1), .out_last(out_last1),
        .out_valid(out_valid1), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Hold the given inputs for one clock edge, returning #1 after it.
    task automatic applyStimulus(input logic v, input logic signed [DW_T-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    // Offer one sample until it is accepted (bounded), out_ready held high.
    task automatic sendSample(input logic signed [DW_T-1:0] d);
        int g;
        g         = 0;
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        while (!in_ready0 && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 200) checkOutput("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    // Reference model: every accepted sample becomes FACTOR queued beats; the
    // head of the queue is what both instances must be presenting.
    always @(negedge clk) begin
        beat_t b;
        logic  rdy_exp;
        if (!rst_n) begin
            exp_q.delete();
            beat_idx = 0;
        end else begin
            rdy_exp = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
            checkOutput("out_valid0", out_valid0, exp_q.size() != 0);
            checkOutput("out_valid1", out_valid1, exp_q.size() != 0);
            checkOutput("in_ready0", in_ready0, rdy_exp);
            checkOutput("in_ready1", in_ready1, rdy_exp);
            if (exp_q.size() != 0) begin
                checkOutput("out_data0", out_data0, exp_q[0].d0);
                checkOutput("out_data1", out_data1, exp_q[0].d1);
                checkOutput("out_last0", out_last0, exp_q[0].last);
                checkOutput("out_last1", out_last1, exp_q[0].last);
                if (out_ready) begin
                    log_q.push_back('{cyc, out_data0, out_data1, out_last0, out_last1});
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && rdy_exp) begin
                for (int p = 0; p < FACTOR_T; p++) begin
                    b.d0   = in_data;
                    b.d1   = (p == 0) ? longint'(in_data) : 0;
                    b.last = ((beat_idx % LAST_T) == LAST_T - 1);
                    beat_idx++;
                    exp_q.push_back(b);
                end
            end
        end
    end

    initial begin
        int L;
        int first_acc;
        longint exp_hold[8];
        longint exp_zs[8];
        exp_hold = '{100, 100, 100, 100, -200, -200, -200, -200};
        exp_zs   = '{100, 0, 0, 0, -200, 0, 0, 0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", out_valid0, 0);
        checkOutput("rst_data", out_data0, 0);
        checkOutput("rst_last", out_last0, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", in_ready0, 1);

        // Two back-to-back samples, hold vs zero-stuff, one beat per clock.
        L = log_q.size();
        sendSample(24'sd100);
        first_acc = acc_cyc;
        sendSample(-24'sd200);
        repeat (4) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("d1_count", log_q.size() - L, 8);
        if (log_q.size() - L == 8) begin
            checkOutput("d1_first_latency", log_q[L].cyc, first_acc);
            for (int i = 0; i < 8; i++) begin
                checkOutput("d1_hold", log_q[L+i].d0, exp_hold[i]);
                checkOutput("d1_zstuff", log_q[L+i].d1, exp_zs[i]);
                checkOutput("d1_cycle", log_q[L+i].cyc - log_q[L].cyc, i);
            end
        end

        // Reset pulse while the held sample is at phase 1.
        sendSample(24'sd55);
        applyStimulus(1'b0, '0, 1'b1);
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, 1'b1);
        rst_n = 1'b1;
        checkOutput("mid_rst_valid0", out_valid0, 0);
        checkOutput("mid_rst_data0", out_data0, 0);
        checkOutput("mid_rst_last0", out_last0, 0);
        checkOutput("mid_rst_valid1", out_valid1, 0);
        checkOutput("mid_rst_in_ready", in_ready0, 1);

        // Continuous input after reset: out_last on beats 6, 12, 18.
        L = log_q.size();
        for (int s = 1; s <= 5; s++) sendSample(24'(s * 11));
        repeat (4) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("d2_count", log_q.size() - L, 20);
        if (log_q.size() - L == 20) begin
            checkOutput("d2_first_zstuff", log_q[L].d1, 11);
            for (int i = 0; i < 20; i++)
                checkOutput("d2_last", log_q[L+i].l0, (i == 5 || i == 11 || i == 17));
        end

        // Back-pressure for 3 cycles at phase 2.
        L = log_q.size();
        sendSample(24'sd321);
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, '0, 1'b0);
            checkOutput("stall_valid", out_valid0, 1);
            checkOutput("stall_data", out_data0, 321);
            checkOutput("stall_in_ready", in_ready0, 0);
        end
        repeat (4) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("stall_beats", log_q.size() - L, 4);

        // Largest positive sample followed by silence.
        L = log_q.size();
        sendSample(24'h7FFFFF);
        repeat (5) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("max_count", log_q.size() - L, 4);
        if (log_q.size() - L == 4)
            for (int i = 0; i < 4; i++) checkOutput("max_data", log_q[L+i].d0, 8388607);
        checkOutput("max_idle_valid", out_valid0, 0);
        checkOutput("max_idle_in_ready", in_ready0, 1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            applyStimulus($urandom_range(0, 9) < 7, DW_T'($urandom), $urandom_range(0, 3) != 0);
        end
        rst_n = 1'b1;
        repeat (10) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("drain_valid", out_valid0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
